// File: rtl/uart_reg_bridge_if.sv
// rtl/uart_reg_bridge_if.sv - rx/tx FIFO and register-bus signals of uart_reg_bridge
interface uart_reg_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_empty;
  logic                  rx_read;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_write;
  logic                  tx_full;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_we;
  logic                  bus_re;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;

  modport master (
    input  rx_data, rx_empty, tx_full, bus_rdata, bus_ack,
    output rx_read, tx_data, tx_write, bus_addr, bus_wdata, bus_we, bus_re
  );

  modport slave (
    output rx_data, rx_empty, tx_full, bus_rdata, bus_ack,
    input  rx_read, tx_data, tx_write, bus_addr, bus_wdata, bus_we, bus_re
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - 'W'/'R' host command engine between uart FIFOs and a register bus
// Optional trailing XOR checksum byte enabled by UART_REG_BRIDGE_CHECKSUM_EN.
module uart_reg_bridge #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int BYTE_TIMEOUT = 65535,
  parameter int BUS_TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_reg_bridge_if.master  bif,
  output logic               busy,
  output logic [7:0]         err_count
);
  localparam int BYTE_CW = $clog2(BYTE_TIMEOUT + 1);
  localparam int BUS_CW  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [BYTE_CW-1:0]    BYTE_LAST = BYTE_CW'(BYTE_TIMEOUT - 1);
  localparam logic [BUS_CW-1:0]     BUS_LAST  = BUS_CW'(BUS_TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] CMD_W = DATA_WIDTH'(8'h57);
  localparam logic [DATA_WIDTH-1:0] CMD_R = DATA_WIDTH'(8'h52);
  localparam logic [DATA_WIDTH-1:0] RSP_K = DATA_WIDTH'(8'h4B);
  localparam logic [DATA_WIDTH-1:0] RSP_E = DATA_WIDTH'(8'h45);

`ifdef UART_REG_BRIDGE_CHECKSUM_EN
  localparam logic [DATA_WIDTH-1:0] RSP_C = DATA_WIDTH'(8'h43);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, GET_CSUM, BUS_WR, BUS_RD, RD_WAIT, SEND} state_t;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND} state_t;
`endif

  state_t                state, state_d;
  logic                  is_wr, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic                  resp_err, resp_err_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_write_q, tx_write_d;
  logic                  rx_read_q, rx_read_d;
  logic [BYTE_CW-1:0]    byte_cnt, byte_cnt_d;
  logic [BUS_CW-1:0]     bus_cnt, bus_cnt_d;
  logic [7:0]            err_d;
  logic                  receiving;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      resp_err   <= 1'b0;
      tx_data_q  <= '0;
      tx_write_q <= 1'b0;
      rx_read_q  <= 1'b0;
      byte_cnt   <= '0;
      bus_cnt    <= '0;
      err_count  <= '0;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state      <= state_d;
      is_wr      <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      resp_err   <= resp_err_d;
      tx_data_q  <= tx_data_d;
      tx_write_q <= tx_write_d;
      rx_read_q  <= rx_read_d;
      byte_cnt   <= byte_cnt_d;
      bus_cnt    <= bus_cnt_d;
      err_count  <= err_d;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // rx_read_q high means the FIFO head is being popped this cycle, so rx_data is captured now.
  always_comb begin
    state_d    = state;
    is_wr_d    = is_wr;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    resp_err_d = resp_err;
    tx_data_d  = tx_data_q;
    tx_write_d = 1'b0;
    byte_cnt_d = '0;
    bus_cnt_d  = '0;
    err_d      = err_count;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state)
      IDLE: begin
        if (rx_read_q) begin
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
          csum_d = bif.rx_data;
`endif
          if (bif.rx_data == CMD_W || bif.rx_data == CMD_R) begin
            is_wr_d = (bif.rx_data == CMD_W);
            state_d = GET_ADDR;
          end else begin
            resp_d     = RSP_E;
            resp_err_d = 1'b1;
            state_d    = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_read_q) begin
          addr_d = ADDR_WIDTH'(bif.rx_data);
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
          csum_d  = csum_q ^ bif.rx_data;
          state_d = is_wr ? GET_DATA : GET_CSUM;
`else
          state_d = is_wr ? GET_DATA : BUS_RD;
`endif
        end else if (byte_cnt == BYTE_LAST) state_d = IDLE;
        else byte_cnt_d = byte_cnt + 1'b1;
      end
      GET_DATA: begin
        if (rx_read_q) begin
          wdata_d = bif.rx_data;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
          csum_d  = csum_q ^ bif.rx_data;
          state_d = GET_CSUM;
`else
          state_d = BUS_WR;
`endif
        end else if (byte_cnt == BYTE_LAST) state_d = IDLE;
        else byte_cnt_d = byte_cnt + 1'b1;
      end
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      GET_CSUM: begin
        if (rx_read_q) begin
          if (bif.rx_data == csum_q) state_d = is_wr ? BUS_WR : BUS_RD;
          else begin
            resp_d     = RSP_C;
            resp_err_d = 1'b1;
            state_d    = SEND;
          end
        end else if (byte_cnt == BYTE_LAST) state_d = IDLE;
        else byte_cnt_d = byte_cnt + 1'b1;
      end
`endif
      BUS_WR: begin
        resp_d     = RSP_K;
        resp_err_d = 1'b0;
        state_d    = SEND;
      end
      BUS_RD, RD_WAIT: begin
        if (bif.bus_ack) begin
          resp_d     = bif.bus_rdata;
          resp_err_d = 1'b0;
          state_d    = SEND;
        end else if (state == RD_WAIT && bus_cnt == BUS_LAST) begin
          resp_d     = RSP_E;
          resp_err_d = 1'b1;
          state_d    = SEND;
        end else begin
          state_d   = RD_WAIT;
          bus_cnt_d = (state == RD_WAIT) ? bus_cnt + 1'b1 : '0;
        end
      end
      SEND: begin
        if (!bif.tx_full) begin
          tx_write_d = 1'b1;
          tx_data_d  = resp_q;
          if (resp_err && err_count != 8'hFF) err_d = err_count + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      IDLE, GET_ADDR, GET_DATA: receiving = 1'b1;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      GET_CSUM:                 receiving = 1'b1;
`endif
      default:                  receiving = 1'b0;
    endcase
    rx_read_d = receiving && !bif.rx_empty && !rx_read_q;
  end

  assign bif.rx_read   = rx_read_q;
  assign bif.tx_data   = tx_data_q;
  assign bif.tx_write  = tx_write_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.bus_we    = (state == BUS_WR);
  assign bif.bus_re    = (state == BUS_RD);
  assign busy          = (state != IDLE);
endmodule
